// File: rtl/cpu_memory.sv
// cpu_memory: memory stage of the CPU pipeline.
// Passes non-memory entries straight to write-back one cycle after capture.
// Turns load/store entries into a single data-memory request, stalls upstream
// until the request is acknowledged, then emits the write-back entry.
// A load flagged as a return redirects fetch via a one-cycle branch pulse.
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   pipeline_control_bits_i, register_write_index_i, reg_result_i,
//   memory_address_i, mem_result_i          : entry from execute
//   dmem_adr_o, dmem_dat_o, dmem_we_o, dmem_stb_o, dmem_dat_i, dmem_ack_i
//                                           : data memory handshake
//   pipeline_control_bits_o, register_write_index_o, reg_result_o
//                                           : entry to write-back
//   stall_o                                 : upstream hold (combinational)
//   branch_flag_o, branch_target_o          : return redirect
module cpu_memory (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  pipeline_control_bits_i,
    input  logic [3:0]  register_write_index_i,
    input  logic [31:0] reg_result_i,
    input  logic [31:0] memory_address_i,
    input  logic [31:0] mem_result_i,
    output logic [31:0] dmem_adr_o,
    output logic [31:0] dmem_dat_o,
    input  logic [31:0] dmem_dat_i,
    output logic        dmem_we_o,
    output logic        dmem_stb_o,
    input  logic        dmem_ack_i,
    output logic [4:0]  pipeline_control_bits_o,
    output logic [3:0]  register_write_index_o,
    output logic [31:0] reg_result_o,
    output logic        stall_o,
    output logic        branch_flag_o,
    output logic [31:0] branch_target_o
);

    localparam int unsigned PCB_W = 5;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned DAT_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [PCB_W-1:0]   pcb_q, pcb_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DAT_W-1:0]   res_q, res_d;
    logic               stb_q, stb_d;
    logic               we_q, we_d;
    logic [DAT_W-1:0]   adr_q, adr_d;
    logic [DAT_W-1:0]   dat_q, dat_d;
    logic [PCB_W-1:0]   pcb_o_q, pcb_o_d;
    logic [IDX_W-1:0]   idx_o_q, idx_o_d;
    logic [DAT_W-1:0]   res_o_q, res_o_d;
    logic               bf_q, bf_d;
    logic [DAT_W-1:0]   bt_q, bt_d;

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        pcb_d   = pcb_q;
        idx_d   = idx_q;
        res_d   = res_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        pcb_o_d = pcb_o_q;
        idx_o_d = idx_o_q;
        res_o_d = res_o_q;
        bf_d    = 1'b0;
        bt_d    = bt_q;

        case (state_q)
            IDLE: begin
                pcb_d = pipeline_control_bits_i;
                idx_d = register_write_index_i;
                res_d = reg_result_i;
                if (pipeline_control_bits_i[1] || pipeline_control_bits_i[2]) begin
                    // Write wins when both write and read are flagged.
                    state_d = WAIT;
                    stb_d   = 1'b1;
                    we_d    = pipeline_control_bits_i[1];
                    adr_d   = memory_address_i;
                    dat_d   = mem_result_i;
                    pcb_o_d = '0;
                end else begin
                    pcb_o_d = pipeline_control_bits_i;
                    idx_o_d = register_write_index_i;
                    res_o_d = reg_result_i;
                end
            end
            WAIT: begin
                pcb_o_d = '0;
                if (dmem_ack_i) begin
                    // Ack edge retires the entry; nothing new is captured here.
                    state_d = IDLE;
                    stb_d   = 1'b0;
                    pcb_o_d = pcb_q;
                    idx_o_d = idx_q;
                    res_o_d = res_q;
                    if (pcb_q[2] && !pcb_q[1]) begin
                        if (pcb_q[4]) begin
                            // Return: loaded word is the target, result keeps stack pointer.
                            bf_d = 1'b1;
                            bt_d = dmem_dat_i;
                        end else begin
                            res_o_d = dmem_dat_i;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any outstanding request.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            pcb_q   <= '0;
            idx_q   <= '0;
            res_q   <= '0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            pcb_o_q <= '0;
            idx_o_q <= '0;
            res_o_q <= '0;
            bf_q    <= 1'b0;
            bt_q    <= '0;
        end else begin
            state_q <= state_d;
            pcb_q   <= pcb_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            pcb_o_q <= pcb_o_d;
            idx_o_q <= idx_o_d;
            res_o_q <= res_o_d;
            bf_q    <= bf_d;
            bt_q    <= bt_d;
        end
    end

    assign stall_o                 = (state_q == WAIT);
    assign dmem_stb_o              = stb_q;
    assign dmem_we_o               = we_q;
    assign dmem_adr_o              = adr_q;
    assign dmem_dat_o              = dat_q;
    assign pipeline_control_bits_o = pcb_o_q;
    assign register_write_index_o  = idx_o_q;
    assign reg_result_o            = res_o_q;
    assign branch_flag_o           = bf_q;
    assign branch_target_o         = bt_q;

endmodule

// File: tb/tb_cpu_memory.sv
// Testbench for cpu_memory: directed scenarios plus randomized transactions
// checked against a transaction-level model of the memory stage.
module tb_cpu_memory;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [4:0]  pcb_i = '0;
    logic [3:0]  idx_i = '0;
    logic [31:0] res_i = '0;
    logic [31:0] addr_i = '0;
    logic [31:0] mdat_i = '0;
    logic [31:0] dmem_adr_o, dmem_dat_o;
    logic [31:0] dmem_dat_i = '0;
    logic        dmem_we_o, dmem_stb_o;
    logic        dmem_ack_i = 1'b0;
    logic [4:0]  pcb_o;
    logic [3:0]  idx_o;
    logic [31:0] res_o;
    logic        stall_o, branch_flag_o;
    logic [31:0] branch_target_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_bt = '0;

    cpu_memory dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .pipeline_control_bits_i (pcb_i),
        .register_write_index_i  (idx_i),
        .reg_result_i            (res_i),
        .memory_address_i        (addr_i),
        .mem_result_i            (mdat_i),
        .dmem_adr_o              (dmem_adr_o),
        .dmem_dat_o              (dmem_dat_o),
        .dmem_dat_i              (dmem_dat_i),
        .dmem_we_o               (dmem_we_o),
        .dmem_stb_o              (dmem_stb_o),
        .dmem_ack_i              (dmem_ack_i),
        .pipeline_control_bits_o (pcb_o),
        .register_write_index_o  (idx_o),
        .reg_result_o            (res_o),
        .stall_o                 (stall_o),
        .branch_flag_o           (branch_flag_o),
        .branch_target_o         (branch_target_o)
    );

    always #5 clk_i = ~clk_i;

    // One entry through the stage. Inputs change on negedge; outputs are
    // checked on negedge. While stalled the upstream inputs carry s_* values,
    // which must be ignored. delay = edges without ack before the ack edge.
    task automatic do_txn(input string tag, input logic [4:0] pcb, input logic [3:0] idx,
                          input logic [31:0] res, input logic [31:0] addr,
                          input logic [31:0] wdat, input int delay, input logic [31:0] rdat,
                          input logic [4:0] s_pcb, input logic [3:0] s_idx,
                          input logic [31:0] s_res);
        logic is_mem, is_wr, is_rd, is_ret;
        logic [31:0] e_res;
        is_mem = pcb[1] | pcb[2];
        is_wr  = pcb[1];
        is_rd  = pcb[2] & ~pcb[1];
        is_ret = is_rd & pcb[4];
        e_res  = (is_rd && !is_ret) ? rdat : res;

        n_tests++;
        if (stall_o !== 1'b0) begin n_fail++; $display("FAIL %s idle_stall: got %b, expected 0", tag, stall_o); end
        pcb_i = pcb; idx_i = idx; res_i = res; addr_i = addr; mdat_i = wdat;
        dmem_ack_i = 1'($urandom);   // no strobe yet, so ack is meaningless
        dmem_dat_i = $urandom;
        @(posedge clk_i);
        @(negedge clk_i);
        pcb_i = s_pcb; idx_i = s_idx; res_i = s_res; addr_i = $urandom; mdat_i = $urandom;
        if (is_mem) begin
            for (int k = 0; k <= delay; k++) begin
                n_tests++;
                if (stall_o !== 1'b1 || dmem_stb_o !== 1'b1 || dmem_we_o !== is_wr ||
                    dmem_adr_o !== addr || dmem_dat_o !== wdat) begin
                    n_fail++;
                    $display("FAIL %s req[%0d]: got stall=%b stb=%b we=%b adr=%h dat=%h, expected 1 1 %b %h %h",
                             tag, k, stall_o, dmem_stb_o, dmem_we_o, dmem_adr_o, dmem_dat_o, is_wr, addr, wdat);
                end
                n_tests++;
                if (pcb_o !== 5'b0 || branch_flag_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s bubble[%0d]: got pcb_o=%b bf=%b, expected 00000 0", tag, k, pcb_o, branch_flag_o);
                end
                dmem_ack_i = (k == delay);
                dmem_dat_i = (k == delay) ? rdat : 32'($urandom);
                @(posedge clk_i);
                @(negedge clk_i);
            end
            dmem_ack_i = 1'b0;
        end
        if (is_ret) exp_bt = rdat;
        n_tests++;
        if (pcb_o !== pcb || idx_o !== idx || res_o !== e_res) begin
            n_fail++;
            $display("FAIL %s wb: got pcb=%b idx=%0d res=%h, expected %b %0d %h", tag, pcb_o, idx_o, res_o, pcb, idx, e_res);
        end
        n_tests++;
        if (stall_o !== 1'b0 || dmem_stb_o !== 1'b0 || branch_flag_o !== is_ret || branch_target_o !== exp_bt) begin
            n_fail++;
            $display("FAIL %s done: got stall=%b stb=%b bf=%b bt=%h, expected 0 0 %b %h",
                     tag, stall_o, dmem_stb_o, branch_flag_o, branch_target_o, is_ret, exp_bt);
        end
        if (is_ret) begin
            // The redirect pulse must last exactly one cycle.
            pcb_i = 5'b0;
            @(posedge clk_i);
            @(negedge clk_i);
            n_tests++;
            if (branch_flag_o !== 1'b0 || branch_target_o !== exp_bt) begin
                n_fail++;
                $display("FAIL %s bf_pulse: got bf=%b bt=%h, expected 0 %h", tag, branch_flag_o, branch_target_o, exp_bt);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (dmem_stb_o !== 1'b0 || dmem_we_o !== 1'b0 || stall_o !== 1'b0 || branch_flag_o !== 1'b0 ||
            pcb_o !== 5'b0 || dmem_adr_o !== 32'b0 || dmem_dat_o !== 32'b0 || res_o !== 32'b0 ||
            branch_target_o !== 32'b0 || idx_o !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_state: got stb=%b we=%b stall=%b bf=%b pcb=%b adr=%h dat=%h res=%h bt=%h idx=%0d, expected all zero",
                     dmem_stb_o, dmem_we_o, stall_o, branch_flag_o, pcb_o, dmem_adr_o, dmem_dat_o, res_o, branch_target_o, idx_o);
        end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_directed();
        do_txn("alu",    5'b00001, 4'd3, 32'h12345678, 32'h0, 32'h0, 0, 32'h0, 5'b0, 4'd0, 32'h0);
        do_txn("store",  5'b00010, 4'd0, 32'h0, 32'h100, 32'hDEADBEEF, 2, 32'h0, 5'b0, 4'd0, 32'h0);
        do_txn("load",   5'b00101, 4'd2, 32'h0, 32'h200, 32'h0, 0, 32'hCAFEF00D, 5'b0, 4'd0, 32'h0);
        do_txn("return", 5'b10101, 4'd1, 32'h0FF8, 32'h0FF8, 32'h0, 1, 32'h00001234, 5'b0, 4'd0, 32'h0);
        do_txn("rw_both",5'b00111, 4'd5, 32'h55AA55AA, 32'h300, 32'h01020304, 1, 32'hFFFFFFFF, 5'b0, 4'd0, 32'h0);
        do_txn("bubble", 5'b00000, 4'd7, 32'h77777777, 32'h0, 32'h0, 0, 32'h0, 5'b0, 4'd0, 32'h0);
    endtask

    task automatic test_back_to_back();
        // ALU op held on the inputs during the load stall must not be taken.
        do_txn("b2b_load", 5'b00101, 4'd9, 32'h0, 32'h400, 32'h0, 3, 32'hA5A5A5A5, 5'b00001, 4'd4, 32'hBBBBBBBB);
        do_txn("b2b_alu",  5'b00001, 4'd4, 32'hBBBBBBBB, 32'h0, 32'h0, 0, 32'h0, 5'b0, 4'd0, 32'h0);
    endtask

    task automatic test_reset_mid_wait();
        pcb_i = 5'b00100; idx_i = 4'd6; res_i = 32'h1; addr_i = 32'h500; mdat_i = 32'h0;
        dmem_ack_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        pcb_i = 5'b00001; idx_i = 4'd8; res_i = 32'h99;
        n_tests++;
        if (dmem_stb_o !== 1'b1 || stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: got stb=%b stall=%b, expected 1 1", dmem_stb_o, stall_o);
        end
        #2 rst_i = 1'b0;
        #1;
        exp_bt = '0;
        n_tests++;
        if (dmem_stb_o !== 1'b0 || stall_o !== 1'b0 || pcb_o !== 5'b0 || dmem_adr_o !== 32'b0) begin
            n_fail++;
            $display("FAIL midrst_async: got stb=%b stall=%b pcb=%b adr=%h, expected 0 0 00000 0",
                     dmem_stb_o, stall_o, pcb_o, dmem_adr_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        do_txn("post_rst_alu", 5'b01001, 4'd8, 32'h99, 32'h0, 32'h0, 0, 32'h0, 5'b0, 4'd0, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            do_txn("rand", 5'($urandom), 4'($urandom), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 4)), $urandom, 5'($urandom), 4'($urandom), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
